// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the unstallable ALU path and a valid/ready long-unit path
// into one registered register-file write per cycle. Define WB_BYPASS_EN for write->read bypass.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_arbiter #(
  parameter int unsigned WORD_SIZE = `WORD_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alu_valid,
  input  logic [4:0]           i_alu_rd,
  input  logic [WORD_SIZE-1:0] i_alu_data,
  input  logic                 i_lu_valid,
  output logic                 o_lu_ready,
  input  logic [4:0]           i_lu_rd,
  input  logic [WORD_SIZE-1:0] i_lu_data,
  input  logic                 i_issue_valid,
  input  logic [4:0]           i_issue_rd,
  output logic [31:0]          o_busy,
  output logic                 o_Wen,
  output logic [4:0]           o_Wnum,
  output logic [WORD_SIZE-1:0] o_Wd,
  input  logic [4:0]           i_Rnum1,
  input  logic [4:0]           i_Rnum2,
  input  logic [WORD_SIZE-1:0] i_Rd1,
  input  logic [WORD_SIZE-1:0] i_Rd2,
  output logic [WORD_SIZE-1:0] o_Rd1,
  output logic [WORD_SIZE-1:0] o_Rd2
);

  logic [4:0]           fifo_rd   [2];
  logic [WORD_SIZE-1:0] fifo_data [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  logic                 push;
  logic                 pop;
  logic [4:0]           head_rd;
  logic [WORD_SIZE-1:0] head_data;
  logic [1:0]           count_next;
  logic [31:0]          busy_next;

  // Ready is held low during reset even though the emptied FIFO would allow it.
  assign o_lu_ready = i_rst_n && (count != 2'd2);

  always_comb begin
    push      = i_lu_valid && o_lu_ready;
    pop       = !i_alu_valid && (count != 2'd0);
    head_rd   = fifo_rd[rd_ptr];
    head_data = fifo_data[rd_ptr];
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Set is applied after clear so a same-cycle issue to the popped register wins.
  always_comb begin
    busy_next = o_busy;
    if (pop && (head_rd != 5'd0))
      busy_next[head_rd] = 1'b0;
    if (i_issue_valid && (i_issue_rd != 5'd0))
      busy_next[i_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= i_lu_rd;
      fifo_data[wr_ptr] <= i_lu_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      o_busy <= '0;
      o_Wen  <= 1'b0;
      o_Wnum <= '0;
      o_Wd   <= '0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      count  <= count_next;
      o_busy <= busy_next;
      if (i_alu_valid) begin
        o_Wen  <= (i_alu_rd != 5'd0);
        o_Wnum <= i_alu_rd;
        o_Wd   <= i_alu_data;
      end else if (pop) begin
        o_Wen  <= (head_rd != 5'd0);
        o_Wnum <= head_rd;
        o_Wd   <= head_data;
      end else begin
        o_Wen  <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    o_Rd1 = i_Rd1;
    o_Rd2 = i_Rd2;
    if (o_Wen && (o_Wnum == i_Rnum1) && (i_Rnum1 != 5'd0))
      o_Rd1 = o_Wd;
    if (o_Wen && (o_Wnum == i_Rnum2) && (i_Rnum2 != 5'd0))
      o_Rd2 = o_Wd;
  end
`else
  always_comb begin
    o_Rd1 = i_Rd1;
    o_Rd2 = i_Rd2;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued by the stimulus
// and popped by a negedge monitor whenever o_Wen is high.
`timescale 1ns/1ps

module tb_wb_arbiter;

  localparam int unsigned W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_alu_valid;
  logic [4:0]   i_alu_rd;
  logic [W-1:0] i_alu_data;
  logic         i_lu_valid;
  logic         o_lu_ready;
  logic [4:0]   i_lu_rd;
  logic [W-1:0] i_lu_data;
  logic         i_issue_valid;
  logic [4:0]   i_issue_rd;
  logic [31:0]  o_busy;
  logic         o_Wen;
  logic [4:0]   o_Wnum;
  logic [W-1:0] o_Wd;
  logic [4:0]   i_Rnum1, i_Rnum2;
  logic [W-1:0] i_Rd1, i_Rd2;
  logic [W-1:0] o_Rd1, o_Rd2;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q [$];

  wb_arbiter #(.WORD_SIZE(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_lu_valid(i_lu_valid), .o_lu_ready(o_lu_ready), .i_lu_rd(i_lu_rd), .i_lu_data(i_lu_data),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_busy(o_busy),
    .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd),
    .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2), .i_Rd1(i_Rd1), .i_Rd2(i_Rd2),
    .o_Rd1(o_Rd1), .o_Rd2(o_Rd2)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge i_clk) begin
    if (o_Wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got x%0d=0x%08h, expected no write", o_Wnum, o_Wd);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({o_Wnum, o_Wd} !== e) begin
          failures++;
          $display("FAIL write_order: got x%0d=0x%08h, expected x%0d=0x%08h",
                   o_Wnum, o_Wd, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic idle();
    i_alu_valid = 1'b0; i_lu_valid = 1'b0; i_issue_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0;
    idle();
    i_alu_rd = '0; i_alu_data = '0; i_lu_rd = '0; i_lu_data = '0; i_issue_rd = '0;
    i_Rnum1 = '0; i_Rnum2 = '0; i_Rd1 = '0; i_Rd2 = '0;
    #2;
    chk("rst_wen",   {31'd0, o_Wen}, 32'd0);
    chk("rst_wnum",  {27'd0, o_Wnum}, 32'd0);
    chk("rst_wd",    o_Wd, 32'd0);
    chk("rst_busy",  o_busy, 32'd0);
    chk("rst_ready", {31'd0, o_lu_ready}, 32'd0);
    step(); step();
    i_rst_n = 1'b1;
    step();

    // ALU write lands one cycle later
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    idle();
    chk("alu_wen", {31'd0, o_Wen}, 32'd1);
    chk("ready_after_reset", {31'd0, o_lu_ready}, 32'd1);
    step(); step();

    // Continuous ALU traffic fills the skid FIFO; long results drain afterwards in order
    i_alu_valid = 1'b1; i_alu_rd = 5'd10; i_alu_data = 32'hA0; expect_wr(5'd10, 32'hA0);
    i_lu_valid = 1'b1; i_lu_rd = 5'd7; i_lu_data = 32'h11;
    step();
    i_alu_rd = 5'd11; i_alu_data = 32'hA1; expect_wr(5'd11, 32'hA1);
    i_lu_rd = 5'd8; i_lu_data = 32'h22;
    chk("ready_one_held", {31'd0, o_lu_ready}, 32'd1);
    step();
    i_lu_valid = 1'b0;
    i_alu_rd = 5'd12; i_alu_data = 32'hA2; expect_wr(5'd12, 32'hA2);
    chk("ready_full", {31'd0, o_lu_ready}, 32'd0);
    step();
    i_alu_rd = 5'd13; i_alu_data = 32'hA3; expect_wr(5'd13, 32'hA3);
    chk("ready_full_alu", {31'd0, o_lu_ready}, 32'd0);
    step();
    idle();
    expect_wr(5'd7, 32'h11);
    expect_wr(5'd8, 32'h22);
    step();
    chk("ready_drain", {31'd0, o_lu_ready}, 32'd1);
    step(); step(); step();

    // x0 destinations are consumed without a write
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hFFFF;
    step();
    idle();
    chk("alu_x0_wen", {31'd0, o_Wen}, 32'd0);
    i_lu_valid = 1'b1; i_lu_rd = 5'd0; i_lu_data = 32'h33;
    step();
    i_lu_valid = 1'b0;
    step();
    chk("lu_x0_wen", {31'd0, o_Wen}, 32'd0);
    chk("busy0", {31'd0, o_busy[0]}, 32'd0);
    step();

    // Scoreboard set, clear on pop, and set winning over a same-cycle clear
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    step();
    i_issue_valid = 1'b0;
    chk("busy9_set", o_busy, 32'h0000_0200);
    i_lu_valid = 1'b1; i_lu_rd = 5'd9; i_lu_data = 32'h99; expect_wr(5'd9, 32'h99);
    step();
    i_lu_valid = 1'b0;
    chk("busy9_held", o_busy, 32'h0000_0200);
    step();
    chk("busy9_clear", o_busy, 32'd0);
    chk("busy9_clear_wen", {31'd0, o_Wen}, 32'd1);
    i_lu_valid = 1'b1; i_lu_rd = 5'd9; i_lu_data = 32'h77; expect_wr(5'd9, 32'h77);
    step();
    i_lu_valid = 1'b0;
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    step();
    i_issue_valid = 1'b0;
    chk("busy9_set_wins", o_busy, 32'h0000_0200);
    step();

    // Read path
    i_Rnum1 = 5'd3; i_Rd1 = 32'd0; i_Rnum2 = 5'd0; i_Rd2 = 32'h5555;
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h1234; expect_wr(5'd3, 32'h1234);
    step();
    idle();
`ifdef WB_BYPASS_EN
    chk("rd1_bypass", o_Rd1, 32'h1234);
`else
    chk("rd1_bypass", o_Rd1, 32'h0);
`endif
    chk("rd2_x0", o_Rd2, 32'h5555);
    step();
    chk("rd1_nowrite", o_Rd1, 32'h0);
    i_Rnum1 = '0; i_Rd2 = '0;

    // Clear busy[9] left over from the previous section via a matching pop
    i_lu_valid = 1'b1; i_lu_rd = 5'd9; i_lu_data = 32'h55; expect_wr(5'd9, 32'h55);
    step();
    i_lu_valid = 1'b0;
    step(); step();
    chk("busy_idle", o_busy, 32'd0);

    // Asynchronous reset with a full FIFO and three busy bits
    i_alu_valid = 1'b1; i_alu_rd = 5'd14; i_alu_data = 32'hB0; expect_wr(5'd14, 32'hB0);
    i_lu_valid = 1'b1; i_lu_rd = 5'd22; i_lu_data = 32'hC0;
    i_issue_valid = 1'b1; i_issue_rd = 5'd21;
    step();
    i_alu_rd = 5'd15; i_alu_data = 32'hB1; expect_wr(5'd15, 32'hB1);
    i_lu_rd = 5'd24; i_lu_data = 32'hC1;
    i_issue_rd = 5'd23;
    step();
    i_alu_rd = 5'd16; i_alu_data = 32'hB2; expect_wr(5'd16, 32'hB2);
    i_lu_valid = 1'b0;
    i_issue_rd = 5'd25;
    step();
    i_issue_valid = 1'b0;
    i_alu_rd = 5'd17; i_alu_data = 32'hB3;
    chk("pre_rst_busy", o_busy, 32'h02A0_0000);
    chk("pre_rst_ready", {31'd0, o_lu_ready}, 32'd0);
    #6;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_wen",   {31'd0, o_Wen}, 32'd0);
    chk("async_rst_busy",  o_busy, 32'd0);
    chk("async_rst_ready", {31'd0, o_lu_ready}, 32'd0);
    chk("async_rst_wd",    o_Wd, 32'd0);
    idle();
    step();
    i_rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, o_lu_ready}, 32'd1);
    repeat (6) step();
    chk("post_rst_busy", o_busy, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that sits directly upstream of the register file and drives its single write port. It merges two producers into one registered write per cycle: the single-cycle ALU path and a long-latency unit (loads or mul/div) that uses a valid/ready handshake. The ALU path always has priority. A 2-entry skid FIFO buffers the long-latency path, and a 32-bit busy scoreboard tracks destinations of issued long ops for the decode stage.

## Interface
- WORD_SIZE: from `WORD_SIZE` in PARAMETERS.vh (32). Data width of every data port.
- FIFO_DEPTH: 2. Long-unit skid FIFO depth. Fixed; not a user parameter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_alu_valid  in  1  ALU result valid this cycle; cannot be stalled
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  WORD_SIZE  ALU result
- i_lu_valid  in  1  long-unit result valid
- o_lu_ready  out  1  arbiter can accept a long-unit result
- i_lu_rd  in  5  long-unit destination register
- i_lu_data  in  WORD_SIZE  long-unit result
- i_issue_valid  in  1  a long op is issued this cycle
- i_issue_rd  in  5  destination of the issued long op
- o_busy  out  32  scoreboard; bit n set means xn has a pending long-op write
- o_Wen  out  1  register-file write enable (registered)
- o_Wnum  out  5  register-file write index (registered)
- o_Wd  out  WORD_SIZE  register-file write data (registered)
- i_Rnum1, i_Rnum2  in  5  decode read indices (bypass)
- i_Rd1, i_Rd2  in  WORD_SIZE  raw register-file read data
- o_Rd1, o_Rd2  out  WORD_SIZE  read data delivered to decode

## Operation
- A long-unit handshake completes when i_lu_valid && o_lu_ready. The result is pushed into the FIFO at that edge.
- o_lu_ready = (FIFO count < 2). It is combinational from the registered count only and does not depend on i_lu_valid or i_alu_valid.
- Arbitration is evaluated each cycle:
  - If i_alu_valid, the ALU wins. The next o_Wen/o_Wnum/o_Wd are loaded from the ALU, and the FIFO head stays in place.
  - Otherwise, if the FIFO is non-empty, the head is popped and loaded into the outputs.
  - Otherwise, o_Wen is 0 next cycle. o_Wnum and o_Wd hold their values.
- x0 rule: a selected entry with rd = 0 is consumed (ALU accepted or FIFO popped), but the next o_Wen is 0.
- Push and pop can occur in the same cycle. The count is unchanged, and a push into a full FIFO is impossible because o_lu_ready = 0.
- FIFO pointers are 1 bit and wrap modulo 2. Order is strictly FIFO.
- Scoreboard:
  - i_issue_valid with i_issue_rd != 0 sets busy[rd].
  - A FIFO pop with rd != 0 clears busy[rd].
  - If set and clear hit the same bit in the same cycle, set wins.
  - busy[0] is always 0.
- Reset (asynchronous, any time, including mid-FIFO):
  - o_Wen = 0, o_Wnum = 0, o_Wd = 0.
  - FIFO is emptied (count = 0, both pointers = 0) and o_busy = 0.
  - o_lu_ready = 0 while i_rst_n is low and 1 from the first cycle after release.
  - In-flight entries are lost.

## Timing
- ALU result presented in cycle N produces o_Wen in cycle N+1. The register file captures it at the end of N+1.
- Long-unit result accepted at the edge ending cycle N is first eligible to pop in N+1. If no ALU traffic, o_Wen is asserted in N+2.
- Under continuous ALU traffic the FIFO never drains. o_lu_ready drops once 2 entries are held, and upstream stalls.
- A scoreboard bit cleared by a pop in cycle N reads 0 in N+1, the same cycle o_Wen is asserted for that write.
- Sustained throughput is one write per cycle.

## Configuration
- WB_BYPASS_EN defined:
  - o_Rd1 = o_Wd when o_Wen && o_Wnum == i_Rnum1 && i_Rnum1 != 0; otherwise o_Rd1 = i_Rd1. Same rule for o_Rd2.
  - Decode therefore sees a value in the same cycle it is being written.
- WB_BYPASS_EN undefined:
  - o_Rd1 = i_Rd1 and o_Rd2 = i_Rd2 (pure pass-through).
  - A read in the same cycle as a write to that register returns the old value.

## Test plan
- Reset release, then i_alu_valid=1, rd=5, data=0xDEADBEEF in cycle 1 -> cycle 2: o_Wen=1, o_Wnum=5, o_Wd=0xDEADBEEF; o_lu_ready=1.
- ALU valid every cycle and long unit offering rd=7 (0x11) then rd=8 (0x22) -> both accepted, then o_lu_ready=0. After the ALU stops, writes appear to x7=0x11 then x8=0x22 on consecutive cycles, and o_lu_ready returns to 1.
- ALU rd=0, data=0xFFFF -> no o_Wen. Long-unit rd=0 -> entry popped, no o_Wen, and busy[0] stays 0.
- Issue rd=9 -> busy[9]=1. Long result rd=9 accepted -> busy[9]=0 in the same cycle o_Wen=1 for x9. Issue rd=9 in the same cycle as the pop -> busy[9] stays 1.
- With WB_BYPASS_EN, write x3=0x1234 while i_Rnum1=3 and i_Rd1=0 -> o_Rd1=0x1234. i_Rnum2=0 -> o_Rd2=i_Rd2. Without WB_BYPASS_EN, o_Rd1=0.
- Assert i_rst_n=0 asynchronously with 2 FIFO entries and 3 busy bits set -> immediately o_Wen=0, o_busy=0, o_lu_ready=0. After release, no stale writes appear.
